// File: rtl/state_pkg.sv
// rtl/state_pkg.sv - shared video FSM state types and frame-memory quad addressing
package state_pkg;

  // Horizontal and vertical timing states used by the display-side controllers
  typedef enum logic [1:0] {S_HIDLE, S_HSYNC, S_HBACK, S_HACTIVE} Hstate_t;
  typedef enum logic [1:0] {S_VIDLE, S_VSYNC, S_VBACK, S_VACTIVE} Vstate_t;

  // Write-side states: waiting for a frame, even line of a pair, odd line of a pair
  typedef enum logic [1:0] {S_WIDLE, S_WEVEN, S_WODD} Wstate_t;

  localparam int LINE_BUF_DEPTH = 256;
  localparam int LINE_BUF_AW    = 8;
  localparam int QUAD_ADDR_W    = 24;

  // One frame-memory word per 2x2 quad; the read controller uses the same mapping
  function automatic logic [QUAD_ADDR_W-1:0] quad_word_addr(
    input logic [11:0] row,
    input logic [11:0] col,
    input logic [10:0] hres
  );
    logic [QUAD_ADDR_W-1:0] w_qrow;
    logic [QUAD_ADDR_W-1:0] w_qcols;
    logic [QUAD_ADDR_W-1:0] w_qcol;
    w_qrow  = QUAD_ADDR_W'(row >> 1);
    w_qcols = QUAD_ADDR_W'(hres >> 1);
    w_qcol  = QUAD_ADDR_W'(col >> 1);
    quad_word_addr = (w_qrow * w_qcols) + w_qcol;
  endfunction

endpackage

// File: rtl/line_pair_buffer.sv
// rtl/line_pair_buffer.sv - one-line store of horizontal pixel pairs, 1W/1R synchronous
module line_pair_buffer
  import state_pkg::*;
#(
  parameter int WIDTH = 48
) (
  input  logic                   i_clk,
  input  logic                   i_wen,
  input  logic [LINE_BUF_AW-1:0] i_waddr,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_ren,
  input  logic [LINE_BUF_AW-1:0] i_raddr,
  output logic [WIDTH-1:0]       o_rdata
);

  logic [WIDTH-1:0] r_mem [0:LINE_BUF_DEPTH-1];

  // Write port: contents are never cleared, every entry is rewritten before it is read
  always_ff @(posedge i_clk) begin
    if (i_wen) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: data appears the cycle after the request
  always_ff @(posedge i_clk) begin
    if (i_ren) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/memory_write_control.sv
// rtl/memory_write_control.sv - packs pixel stream into 2x2 quads and writes frame memory
module memory_write_control
  import state_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int MEM_WIDTH  = DATA_WIDTH * 4,
  parameter int ADDR_DEPTH = 512 * 512 / 4,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  i_vsync,
  input  logic                  i_de,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [10:0]           i_hres,
  input  logic [10:0]           i_vres,
  output logic                  o_wen,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [MEM_WIDTH-1:0]  o_wdata,
  output logic                  o_frame_done
);

  Wstate_t                 r_state;
  logic                    r_vsync_d;
  logic                    r_de_d;
  logic [11:0]             r_col;
  logic [11:0]             r_row;
  logic [DATA_WIDTH-1:0]   r_even_pix;
  logic                    r_wen;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [MEM_WIDTH-1:0]    r_wdata;
  logic                    r_frame_done;

  logic                    w_vsync_rise;
  logic                    w_de_fall;
  logic                    w_in_line;
  logic                    w_pix;
  logic                    w_odd_col;
  logic [11:0]             w_pair_rows;
  logic [11:0]             w_row_next;
  logic                    w_rows_done;
  logic                    w_last_qrow;
  logic                    w_last_qcol;
  logic                    w_buf_wen;
  logic                    w_buf_ren;
  logic                    w_quad_write;
  logic [LINE_BUF_AW-1:0]  w_buf_addr;
  logic [2*DATA_WIDTH-1:0] w_buf_wdata;
  logic [2*DATA_WIDTH-1:0] w_buf_rdata;

  assign w_vsync_rise = i_vsync & ~r_vsync_d;
  assign w_de_fall    = ~i_de & r_de_d;
  // Pixels past the active width are dropped and stop the column counter
  assign w_in_line    = (r_col < {1'b0, i_hres});
  assign w_pix        = i_de & w_in_line & (r_state != S_WIDLE);
  assign w_odd_col    = r_col[0];

  // Only complete line pairs are stored; an odd trailing line is never paired
  assign w_pair_rows  = {1'b0, i_vres & 11'h7FE};
  assign w_row_next   = r_row + 12'd1;
  assign w_rows_done  = (w_row_next >= w_pair_rows);
  assign w_last_qrow  = (w_row_next == w_pair_rows);
  assign w_last_qcol  = (r_col[11:1] == ((i_hres >> 1) - 11'd1));

  assign w_buf_wen    = (r_state == S_WEVEN) & w_pix & w_odd_col;
  assign w_buf_ren    = (r_state == S_WODD) & w_pix & ~w_odd_col;
  assign w_quad_write = (r_state == S_WODD) & w_pix & w_odd_col;
  assign w_buf_addr   = r_col[8:1];
  assign w_buf_wdata  = {r_even_pix, i_data};

  line_pair_buffer #(
    .WIDTH (2 * DATA_WIDTH)
  ) u_line_pair_buffer (
    .i_clk   (i_clk),
    .i_wen   (w_buf_wen),
    .i_waddr (w_buf_addr),
    .i_wdata (w_buf_wdata),
    .i_ren   (w_buf_ren),
    .i_raddr (w_buf_addr),
    .o_rdata (w_buf_rdata)
  );

  // Frame/line FSM with counters and registered memory write port
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_WIDLE;
      r_vsync_d    <= 1'b0;
      r_de_d       <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_even_pix   <= '0;
      r_wen        <= 1'b1;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_vsync_d    <= i_vsync;
      r_de_d       <= i_de;
      r_wen        <= 1'b1;
      r_frame_done <= 1'b0;
      if (w_vsync_rise) begin
        // Frame start or restart wins over any line activity this cycle
        r_state <= S_WEVEN;
        r_row   <= '0;
        r_col   <= '0;
      end else if (r_state != S_WIDLE) begin
        if (w_de_fall) begin
          r_col <= '0;
          r_row <= w_row_next;
          if (w_rows_done) begin
            r_state <= S_WIDLE;
          end else if (r_state == S_WEVEN) begin
            r_state <= S_WODD;
          end else begin
            r_state <= S_WEVEN;
          end
        end else if (w_pix) begin
          r_col <= r_col + 12'd1;
          if (!w_odd_col) begin
            r_even_pix <= i_data;
          end
          if (w_quad_write) begin
            r_wen        <= 1'b0;
            r_waddr      <= ADDR_WIDTH'(quad_word_addr(r_row, r_col, i_hres));
            r_wdata      <= MEM_WIDTH'({w_buf_rdata, r_even_pix, i_data});
            r_frame_done <= w_last_qrow & w_last_qcol;
          end
        end
      end
    end
  end

  assign o_wen        = r_wen;
  assign o_waddr      = r_waddr;
  assign o_wdata      = r_wdata;
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/memory_write_control.md
MEMORY_WRITE_CONTROL -- requirements
Module: memory_write_control

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, pixel width.
REQ-002 SHALL have parameter MEM_WIDTH, default DATA_WIDTH*4, frame-memory word width holding one 2x2 pixel quad.
REQ-003 SHALL have parameter ADDR_DEPTH, default 512*512/4, frame-memory words.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(ADDR_DEPTH), word-address width.
REQ-005 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port i_vsync  input  1  frame start, active-high level.
REQ-008 SHALL have port i_de  input  1  input pixel valid.
REQ-009 SHALL have port i_data  input  DATA_WIDTH  input pixel.
REQ-010 SHALL have port i_hres  input  11  active pixels per line.
REQ-011 SHALL have port i_vres  input  11  active lines per frame.
REQ-012 SHALL have port o_wen  output  1  memory write enable, active-low.
REQ-013 SHALL have port o_waddr  output  ADDR_WIDTH  memory word address.
REQ-014 SHALL have port o_wdata  output  MEM_WIDTH  memory word.
REQ-015 SHALL have port o_frame_done  output  1  one-cycle pulse after the last quad of a frame.

Function
REQ-016 SHALL run FSM Wstate_t: S_WIDLE, S_WEVEN, S_WODD.
REQ-017 SHALL move S_WIDLE->S_WEVEN on the i_vsync rising edge, clearing rowCnt and colCnt to 0.
REQ-018 SHALL count colCnt (12 bit) on each i_de cycle; clear it on the i_de falling edge.
REQ-019 SHALL, on each i_de falling edge, increment rowCnt and move S_WEVEN->S_WODD; from S_WODD go to S_WEVEN, or to S_WIDLE when rowCnt==i_vres-1.
REQ-020 SHALL, in S_WEVEN, latch even-column pixels and, on odd-column pixels, write {even,odd} (2*DATA_WIDTH) into line buffer entry colCnt>>1.
REQ-021 SHALL, in S_WODD, issue line-buffer read of entry colCnt>>1 on even-column pixels; the data is valid on the following odd-column cycle.
REQ-022 SHALL form o_wdata = {evenLine_evenPix[95:72], evenLine_oddPix[71:48], oddLine_evenPix[47:24], oddLine_oddPix[23:0]}.
REQ-023 SHALL compute o_waddr = (rowCnt>>1)*(i_hres>>1) + (colCnt>>1), truncated to ADDR_WIDTH.
REQ-024 SHALL register o_wen/o_waddr/o_wdata: o_wen low exactly one cycle, one cycle after the odd-line odd-column pixel.
REQ-025 SHALL pulse o_frame_done one cycle, coincident with the final o_wen low of row i_vres-1.
REQ-026 SHALL drop an unpaired last pixel when i_hres is odd, and never write a trailing unpaired even line when i_vres is odd.
REQ-027 SHALL ignore i_de in S_WIDLE and ignore pixels beyond i_hres in a line.
REQ-028 SHALL treat an i_vsync rising edge in any state as a frame restart (S_WEVEN, counters 0) with no write issued that cycle.

Reset
REQ-029 SHALL, while rst is high, force state S_WIDLE, rowCnt=0, colCnt=0, o_wen=1, o_waddr=0, o_wdata=0, o_frame_done=0.
REQ-030 SHALL, on rst mid-frame, abandon the frame; the next write occurs only after a fresh i_vsync rising edge.
REQ-031 SHALL not require line-buffer contents to be reset.

Structure
REQ-032 SHALL place Wstate_t in shared package state_pkg alongside the existing Hstate_t/Vstate_t.
REQ-033 SHALL instantiate one sub-module line_pair_buffer: 256 x 2*DATA_WIDTH, one write port, one synchronous read port.
REQ-034 SHALL keep o_waddr arithmetic identical to the downstream read control's word addressing (quad per (row>>1, col>>1)).

Verification
REQ-035 SHALL test: rst high mid-line with i_de=1 -> o_wen stays 1, outputs 0, no write until next vsync.
REQ-036 SHALL test: hres=4, vres=2, pixels 0x000001..0x000008 row-major -> two writes: addr 0 = {000001,000002,000005,000006}, addr 1 = {000003,000004,000007,000008}; o_frame_done with addr 1.
REQ-037 SHALL test: hres=512, vres=512 ramp -> 65536 writes, last addr 65535, single o_frame_done.
REQ-038 SHALL test: hres=5, vres=3 -> exactly 2 writes (addr 0,1), fifth column and third row never written.
REQ-039 SHALL test: vsync rising edge after row 1 of hres=4 frame -> rows restart at 0, next write to addr 0.
REQ-040 SHALL test: i_de asserted while in S_WIDLE -> no write, no line-buffer update visible in later frame data.
